// File: rtl/jk_pkg.sv
// jk_pkg: shared mode encodings for the JK multimode register.
//   MODE_JK  per-bit JK set/clear/toggle
//   MODE_UP  synchronous up counter
//   MODE_DN  synchronous down counter
//   MODE_SH  shift left with serial input into bit 0
package jk_pkg;
    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_UP = 2'b01;
    localparam logic [1:0] MODE_DN = 2'b10;
    localparam logic [1:0] MODE_SH = 2'b11;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop bit with synchronous active-low reset.
//   clk      rising-edge clock
//   reset    synchronous active-low reset, loads rst_val
//   en       clock enable; 0 holds q
//   j, k     JK inputs: 00 hold, 01 clear, 10 set, 11 toggle
//   rst_val  value loaded on reset
//   q        stored bit
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic j,
    input  logic k,
    input  logic rst_val,
    output logic q
);
    // Characteristic equation: set when j and q is low, keep when k is low and q is high.
    always_ff @(posedge clk)
        if (!reset)
            q <= rst_val;
        else if (en)
            q <= (j & ~q) | (~k & q);
endmodule

// File: rtl/jk_multimode_register.sv
// jk_multimode_register: WIDTH-bit JK register with JK, count-up, count-down and shift modes.
//   clk      rising-edge clock
//   reset    synchronous active-low reset, loads RST_VAL
//   en       clock enable; 0 holds all state
//   mode     00 JK, 01 count up, 10 count down, 11 shift
//   J, K     per-bit JK inputs (JK mode only)
//   ser_in   serial input to bit 0 (shift mode only)
//   Q, Qn    register state and its complement
//   tc       terminal count: all ones while counting up, zero while counting down
//   ser_out  Q[WIDTH-1]
module jk_multimode_register
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             ser_in,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             tc,
    output logic             ser_out
);
    logic [WIDTH-1:0] up_c, dn_c, src, j_s, k_s;
    // Ripple carry chains: a bit toggles when all lower bits are ones (up) or zeros (down).
    always_comb begin
        up_c[0] = 1'b1;
        dn_c[0] = 1'b1;
        for (int b = 1; b < WIDTH; b++) begin
            up_c[b] = up_c[b-1] & Q[b-1];
            dn_c[b] = dn_c[b-1] & ~Q[b-1];
        end
    end
    assign src = {Q[WIDTH-2:0], ser_in};
    // Shift uses j=src, k=~src so each cell loads its source bit directly.
    assign j_s = mode == MODE_JK ? J : mode == MODE_UP ? up_c : mode == MODE_DN ? dn_c : src;
    assign k_s = mode == MODE_JK ? K : mode == MODE_UP ? up_c : mode == MODE_DN ? dn_c : ~src;
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk    (clk),
            .reset  (reset),
            .en     (en),
            .j      (j_s[i]),
            .k      (k_s[i]),
            .rst_val(RST_VAL[i]),
            .q      (Q[i])
        );
    end
    assign Qn      = ~Q;
    assign tc      = (mode == MODE_UP && &Q) || (mode == MODE_DN && ~|Q);
    assign ser_out = Q[WIDTH-1];
endmodule
